// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumer.
//   en        : advance raster one pixel this cycle (consumer -> generator)
//   sx, sy    : current raster position
//   hsync     : horizontal sync
//   vsync     : vertical sync
//   de        : data enable (active video)
//   vblank    : vertical blanking
//   line      : one-cycle line-start strobe
//   frame     : one-cycle frame-start strobe
//   frame_cnt : frames started since reset
interface vga_timing_gen_if #(
    parameter int unsigned CORDW  = 16,
    parameter int unsigned FRAMEW = 8
);
    logic              en;
    logic [CORDW-1:0]  sx;
    logic [CORDW-1:0]  sy;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              vblank;
    logic              line;
    logic              frame;
    logic [FRAMEW-1:0] frame_cnt;

    modport master (
        input  en,
        output sx, sy, hsync, vsync, de, vblank, line, frame, frame_cnt
    );

    modport slave (
        output en,
        input  sx, sy, hsync, vsync, de, vblank, line, frame, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator.
//   clk_pix : pixel clock
//   rst_pix : asynchronous active-high reset
//   vga     : raster bundle (en in; position, syncs, de, vblank, strobes,
//             frame counter out), all outputs registered and aligned to
//             the same pixel.
module vga_timing_gen #(
    parameter int unsigned CORDW  = 16,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned H_POL  = 0,
    parameter int unsigned V_POL  = 0,
    parameter int unsigned FRAMEW = 8
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    vga_timing_gen_if.master  vga
);

    localparam int unsigned H_TOTAL    = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_FP_END   = H_RES + H_FP;
    localparam int unsigned H_SYNC_END = H_FP_END + H_SYNC;
    localparam int unsigned V_FP_END   = V_RES + V_FP;
    localparam int unsigned V_SYNC_END = V_FP_END + V_SYNC;
    localparam logic        HS_ON      = 1'(H_POL);
    localparam logic        VS_ON      = 1'(V_POL);

    // Reject parameter sets the counters or phase FSMs cannot represent.
    if ((64'(1) << CORDW) <= 64'(H_TOTAL - 1) ||
        (64'(1) << CORDW) <= 64'(V_TOTAL - 1)) begin : g_bad_cordw
        $error("vga_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: sync and porch widths must be non-zero");
    end

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    phase_e              h_state_q, h_state_d;
    phase_e              v_state_q, v_state_d;
    logic [CORDW-1:0]    sx_q, sx_d;
    logic [CORDW-1:0]    sy_q, sy_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                de_q, de_d;
    logic                vblank_q, vblank_d;
    logic                line_q, line_d;
    logic                frame_q, frame_d;
    logic [FRAMEW-1:0]   frame_cnt_q, frame_cnt_d;
    logic                h_wrap;
    logic                v_wrap;

    assign h_wrap = (sx_q == CORDW'(H_TOTAL - 1));
    assign v_wrap = (sy_q == CORDW'(V_TOTAL - 1));

    // State and output registers; reset parks the raster at the last pixel
    // of back porch so the first enabled cycle lands on (0,0).
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            h_state_q   <= PH_BP;
            v_state_q   <= PH_BP;
            sx_q        <= CORDW'(H_TOTAL - 1);
            sy_q        <= CORDW'(V_TOTAL - 1);
            hsync_q     <= ~HS_ON;
            vsync_q     <= ~VS_ON;
            de_q        <= 1'b0;
            vblank_q    <= 1'b1;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            h_state_q   <= h_state_d;
            v_state_q   <= v_state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            vblank_q    <= vblank_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next position and phase; vertical steps only on a horizontal wrap.
    always_comb begin
        sx_d      = sx_q;
        sy_d      = sy_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (vga.en) begin
            sx_d = h_wrap ? '0 : sx_q + CORDW'(1);
            unique case (h_state_q)
                PH_ACTIVE: if (sx_q == CORDW'(H_RES - 1))      h_state_d = PH_FP;
                PH_FP:     if (sx_q == CORDW'(H_FP_END - 1))   h_state_d = PH_SYNC;
                PH_SYNC:   if (sx_q == CORDW'(H_SYNC_END - 1)) h_state_d = PH_BP;
                PH_BP:     if (h_wrap)                         h_state_d = PH_ACTIVE;
            endcase
            if (h_wrap) begin
                sy_d = v_wrap ? '0 : sy_q + CORDW'(1);
                unique case (v_state_q)
                    PH_ACTIVE: if (sy_q == CORDW'(V_RES - 1))      v_state_d = PH_FP;
                    PH_FP:     if (sy_q == CORDW'(V_FP_END - 1))   v_state_d = PH_SYNC;
                    PH_SYNC:   if (sy_q == CORDW'(V_SYNC_END - 1)) v_state_d = PH_BP;
                    PH_BP:     if (v_wrap)                         v_state_d = PH_ACTIVE;
                endcase
            end
        end
    end

    // Outputs decoded from the next phase so they register alongside sx/sy.
    always_comb begin
        hsync_d     = ~HS_ON;
        vsync_d     = ~VS_ON;
        de_d        = 1'b0;
        vblank_d    = 1'b1;
        line_d      = 1'b0;
        frame_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (h_state_d == PH_SYNC) hsync_d = HS_ON;
        if (v_state_d == PH_SYNC) vsync_d = VS_ON;
        de_d     = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
        vblank_d = (v_state_d != PH_ACTIVE);
        line_d   = vga.en && h_wrap;
        frame_d  = vga.en && h_wrap && v_wrap;
        if (frame_d) frame_cnt_d = frame_cnt_q + FRAMEW'(1);
    end

    assign vga.sx        = sx_q;
    assign vga.sy        = sy_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.de        = de_q;
    assign vga.vblank    = vblank_q;
    assign vga.line      = line_q;
    assign vga.frame     = frame_q;
    assign vga.frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/DVI raster timing generator, successor to the fixed 640x480 VGA_Timing block. Driven by the pixel clock from VGA_Clock. Timing comes from porch/sync parameters, so one block covers any resolution. Adds a pixel-advance enable, programmable sync polarity, line/frame start strobes, vblank and a frame counter for game-loop pacing.

Parameters:
CORDW, 16, width of sx/sy; must hold H_TOTAL-1 and V_TOTAL-1.
H_RES, 640, active pixels per line.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, horizontal sync width (pixels).
H_BP, 48, horizontal back porch (pixels).
V_RES, 480, active lines.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BP, 33, vertical back porch (lines).
H_POL, 0, hsync active level (0 = active-low, 1 = active-high).
V_POL, 0, vsync active level (0 = active-low, 1 = active-high).
FRAMEW, 8, frame_cnt width.

Ports:
clk_pix  input  1  pixel clock
rst_pix  input  1  asynchronous, active-high reset
en  input  1  advance raster one pixel this cycle
sx  output  CORDW  current horizontal position
sy  output  CORDW  current vertical position
hsync  output  1  horizontal sync, polarity H_POL
vsync  output  1  vertical sync, polarity V_POL
de  output  1  data enable (active video)
vblank  output  1  high while sy >= V_RES
line  output  1  one-cycle strobe on entry to sx=0
frame  output  1  one-cycle strobe on entry to (0,0)
frame_cnt  output  FRAMEW  frames started since reset, wraps

Behaviour:
- H_TOTAL = H_RES+H_FP+H_SYNC+H_BP. V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
- Elaboration error if 2^CORDW <= H_TOTAL-1 or 2^CORDW <= V_TOTAL-1.
- Elaboration error if any sync or porch parameter is 0.
- All outputs are registered, and all describe the same pixel (sx,sy) in the same cycle. There is no skew between coordinates and sync/de.
- Reset (async assert; deassert synchronised by the user via clk_pix_locked):
  - sx=H_TOTAL-1, sy=V_TOTAL-1.
  - hsync=~H_POL, vsync=~V_POL.
  - de=0, vblank=1, line=0, frame=0, frame_cnt=0.
- Horizontal phase FSM: ACTIVE(sx<H_RES) -> FP -> SYNC -> BP -> ACTIVE.
  - Transitions occur only on en cycles, at the phase boundary counts.
  - The FSM is held in reset state BP (the position is at the end of BP).
- Vertical phase FSM: same four phases over sy.
  - Advances only on en cycles where sx wraps from H_TOTAL-1 to 0.
- On each en=1 cycle:
  - sx increments; at H_TOTAL-1 it wraps to 0.
  - On a horizontal wrap, sy increments; at V_TOTAL-1 it wraps to 0.
- en=0: sx, sy, hsync, vsync, de, vblank and frame_cnt hold. line=0, frame=0.
- hsync active iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC.
- vsync active iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, for whole lines. It changes in the same cycle as sy.
- de = (sx<H_RES) && (sy<V_RES).
- line=1 only in the cycle following an en cycle that moved sx to 0.
- frame=1 only when line=1 and sy=0.
- frame_cnt increments, modulo 2^FRAMEW, in the cycle frame asserts. The first frame after reset reads 1.
- Reset mid-frame: all outputs immediately return to their reset values, including frame_cnt. The first en cycle after release gives (0,0) with frame=1.

Test Plan:
- Defaults, en tied high, release reset -> first cycle sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=1, hsync=1, vsync=1.
- Defaults, one full line -> hsync=0 exactly for sx 656..751 (96 cycles); de=1 for sx 0..639; line period 800 cycles.
- Defaults, one full frame -> vsync=0 for sy 490..491 (1600 cycles); vblank=1 for sy 480..524; frame period 420000 cycles; frame_cnt=2 at the second frame.
- Toggle en 1/0 every cycle -> each position lasts 2 cycles, frame period 840000; line/frame strobes stay 1 cycle wide.
- Assert rst_pix at sx=300, sy=200 -> outputs are at reset values asynchronously; after release the first en cycle gives (0,0), frame=1, frame_cnt=1.
- Parameter set H 800/40/128/88, V 600/1/4/23, H_POL=V_POL=1, FRAMEW=2 -> H_TOTAL=1056, V_TOTAL=628; hsync=1 for sx 840..967; vsync=1 for sy 601..604; frame_cnt wraps 3 -> 0 on the fourth frame.
